// File: rtl/warmboot_sequencer.sv
// Warmboot sequencer: picks one of four images from a debounced button or a
// fabric request and drives SB_WARMBOOT BOOT/S1/S0 with a select-setup window.
// Ports:
//   CLK, RST_N           clock, synchronous active-low reset
//   BTN_N                raw asynchronous push button, active-low
//   REQ_VALID/REQ_IMAGE  fabric warmboot request and image index
//   REQ_READY            request accepted when REQ_VALID & REQ_READY
//   IMG                  currently selected image
//   LED                  status indicator, active-high
//   BOOT/S1/S0           to SB_WARMBOOT
module warmboot_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 65536,
  parameter int unsigned LONG_CYCLES     = 6000000,
  parameter int unsigned BLINK_CYCLES    = 1500000,
  parameter int unsigned BLINKS          = 8,
  parameter int unsigned SETUP_CYCLES    = 16
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       BTN_N,
  input  logic       REQ_VALID,
  input  logic [1:0] REQ_IMAGE,
  output logic       REQ_READY,
  output logic [1:0] IMG,
  output logic       LED,
  output logic       BOOT,
  output logic       S1,
  output logic       S0
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HW = $clog2(LONG_CYCLES + 1);
  localparam int unsigned BW = $clog2(BLINK_CYCLES + 1);
  localparam int unsigned TW = $clog2(BLINKS + 1);
  localparam int unsigned SW = $clog2(SETUP_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HELD,
    S_COUNTDOWN,
    S_SETUP,
    S_BOOT
  } state_t;

  // Button path: synchronizer, debounce and edge pulses.
  logic          sync1_q, sync2_q;
  logic          deb_q, deb_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          press_q, press_d;
  logic          release_q, release_d;

  // Sequencer registers.
  state_t        state_q, state_d;
  logic [1:0]    img_q, img_d;
  logic          led_q, led_d;
  logic          boot_q, boot_d;
  logic          s1_q, s1_d;
  logic          s0_q, s0_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [BW-1:0] blink_q, blink_d;
  logic [TW-1:0] tog_q, tog_d;
  logic [SW-1:0] setup_q, setup_d;

  // Debounced level flips on the Nth consecutive disagreeing sample.
  always_comb begin
    deb_d     = deb_q;
    dcnt_d    = '0;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (sync2_q != deb_q) begin
      if (dcnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
        deb_d     = ~deb_q;
        press_d   = deb_q;
        release_d = ~deb_q;
      end else begin
        dcnt_d = dcnt_q + DW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      deb_q     <= 1'b1;
      dcnt_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= BTN_N;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      dcnt_q    <= dcnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Only idle with the button released can take a request, so a button
  // gesture and a fabric request never race.
  assign REQ_READY = (state_q == S_IDLE) && deb_q;

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    img_d   = img_q;
    led_d   = led_q;
    boot_d  = boot_q;
    hold_d  = hold_q;
    blink_d = blink_q;
    tog_d   = tog_q;
    setup_d = setup_q;
    unique case (state_q)
      S_IDLE: begin
        led_d = 1'b0;
        if (REQ_VALID && REQ_READY) begin
          img_d   = REQ_IMAGE;
          setup_d = '0;
          led_d   = 1'b1;
          state_d = S_SETUP;
        end else if (press_q) begin
          hold_d  = '0;
          state_d = S_HELD;
        end
      end
      S_HELD: begin
        if (release_q) begin
          img_d   = img_q + 2'd1;
          state_d = S_IDLE;
        end else if (hold_q == HW'(LONG_CYCLES - 1)) begin
          led_d   = 1'b1;
          blink_d = '0;
          tog_d   = '0;
          state_d = S_COUNTDOWN;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      S_COUNTDOWN: begin
        // Abort has priority even over the final toggle.
        if (press_q) begin
          led_d   = 1'b0;
          state_d = S_IDLE;
        end else if (blink_q == BW'(BLINK_CYCLES - 1)) begin
          blink_d = '0;
          led_d   = ~led_q;
          if (tog_q == TW'(BLINKS - 1)) begin
            led_d   = 1'b1;
            setup_d = '0;
            state_d = S_SETUP;
          end else begin
            tog_d = tog_q + TW'(1);
          end
        end else begin
          blink_d = blink_q + BW'(1);
        end
      end
      S_SETUP: begin
        led_d = 1'b1;
        if (setup_q == SW'(SETUP_CYCLES - 1)) begin
          boot_d  = 1'b1;
          state_d = S_BOOT;
        end else begin
          setup_d = setup_q + SW'(1);
        end
      end
      S_BOOT: begin
        boot_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Selects track the image; the image is frozen outside IDLE/HELD.
    s1_d = img_d[1];
    s0_d = img_d[0];
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      img_q   <= '0;
      led_q   <= 1'b0;
      boot_q  <= 1'b0;
      s1_q    <= 1'b0;
      s0_q    <= 1'b0;
      hold_q  <= '0;
      blink_q <= '0;
      tog_q   <= '0;
      setup_q <= '0;
    end else begin
      state_q <= state_d;
      img_q   <= img_d;
      led_q   <= led_d;
      boot_q  <= boot_d;
      s1_q    <= s1_d;
      s0_q    <= s0_d;
      hold_q  <= hold_d;
      blink_q <= blink_d;
      tog_q   <= tog_d;
      setup_q <= setup_d;
    end
  end

  assign IMG  = img_q;
  assign LED  = led_q;
  assign BOOT = boot_q;
  assign S1   = s1_q;
  assign S0   = s0_q;

endmodule

// File: tb/tb_warmboot_sequencer.sv
// Self-checking bench for warmboot_sequencer with a timestamp-based reference model.
module tb_warmboot_sequencer;

  localparam int DEB   = 4;
  localparam int LONG  = 20;
  localparam int BLINK = 8;
  localparam int NBL   = 4;
  localparam int SETUP = 16;

  localparam int MD_IDLE = 0;
  localparam int MD_HELD = 1;
  localparam int MD_CD   = 2;
  localparam int MD_SET  = 3;
  localparam int MD_BOOT = 4;

  logic       clk = 1'b0;
  logic       rst_n, btn_n, req_valid;
  logic [1:0] req_image;
  logic       req_ready, led, boot, s1, s0;
  logic [1:0] img;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  warmboot_sequencer #(
    .DEBOUNCE_CYCLES(DEB),
    .LONG_CYCLES    (LONG),
    .BLINK_CYCLES   (BLINK),
    .BLINKS         (NBL),
    .SETUP_CYCLES   (SETUP)
  ) dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .BTN_N    (btn_n),
    .REQ_VALID(req_valid),
    .REQ_IMAGE(req_image),
    .REQ_READY(req_ready),
    .IMG      (img),
    .LED      (led),
    .BOOT     (boot),
    .S1       (s1),
    .S0       (s0)
  );

  // Reference model: spec rules expressed with timestamps of mode entry.
  int m_mode = MD_IDLE;
  int m_img  = 0;
  bit m_led  = 0;
  bit m_boot = 0;
  bit m_sa   = 1;
  bit m_sb   = 1;
  bit m_deb  = 1;
  int m_run  = 0;
  bit m_press = 0;
  bit m_rel  = 0;
  int m_t0   = 0;
  int m_cyc  = 0;

  task automatic model_step();
    bit rdy, nd, np, nr;
    int el;
    if (!rst_n) begin
      m_mode = MD_IDLE; m_img = 0; m_led = 0; m_boot = 0;
      m_sa = 1; m_sb = 1; m_deb = 1; m_run = 0; m_press = 0; m_rel = 0; m_t0 = 0;
      m_cyc++;
      return;
    end
    rdy = (m_mode == MD_IDLE) && m_deb;
    el  = m_cyc - m_t0;
    case (m_mode)
      MD_IDLE: begin
        m_led = 0;
        if (req_valid && rdy) begin
          m_img = int'(req_image); m_mode = MD_SET; m_t0 = m_cyc; m_led = 1;
        end else if (m_press) begin
          m_mode = MD_HELD; m_t0 = m_cyc;
        end
      end
      MD_HELD: begin
        if (m_rel) begin
          m_img = (m_img + 1) % 4; m_mode = MD_IDLE;
        end else if (el == LONG) begin
          m_mode = MD_CD; m_t0 = m_cyc; m_led = 1;
        end
      end
      MD_CD: begin
        if (m_press) begin
          m_mode = MD_IDLE; m_led = 0;
        end else if (el % BLINK == 0) begin
          m_led = !m_led;
          if (el == BLINK * NBL) begin
            m_mode = MD_SET; m_t0 = m_cyc; m_led = 1;
          end
        end
      end
      MD_SET: begin
        if (el == SETUP) begin
          m_mode = MD_BOOT; m_boot = 1;
        end
      end
      default: ;
    endcase
    np = 0; nr = 0; nd = m_deb;
    if (m_sb != m_deb) begin
      m_run++;
      if (m_run == DEB) begin
        nd = !m_deb; m_run = 0; np = m_deb; nr = !m_deb;
      end
    end else begin
      m_run = 0;
    end
    m_deb = nd; m_press = np; m_rel = nr;
    m_sb = m_sa; m_sa = btn_n;
    m_cyc++;
  endtask

  function automatic logic [7:0] model_vec();
    logic [1:0] mi;
    mi = 2'(m_img);
    return {1'b0, mi, m_led, m_boot, mi[1], mi[0], (m_mode == MD_IDLE) && m_deb};
  endfunction

  function automatic logic [7:0] dut_vec();
    return {1'b0, img, led, boot, s1, s0, req_ready};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("cycle_vs_model", dut_vec(), model_vec());
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_led(input logic v, input int max, input string tag);
    bit hit;
    hit = 0;
    for (int i = 0; i < max && !hit; i++) begin
      tick();
      if (led === v) hit = 1;
    end
    check(tag, 8'(hit), 8'd1);
  endtask

  task automatic short_press(input int hold);
    btn_n = 1'b0;
    ticks(hold);
    btn_n = 1'b1;
    ticks(10);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int chg[8];
    int nchg, boot_at, k, nb;
    logic prev_led;

    rst_n = 1'b0; btn_n = 1'b1; req_valid = 1'b0; req_image = 2'd0;
    tick(); tick();
    rst_n = 1'b1;
    check("reset_img", 8'(img), 8'd0);
    check("reset_led_boot", 8'({led, boot, s1, s0}), 8'd0);
    check("reset_ready", 8'(req_ready), 8'd1);

    // Glitch rejection
    repeat (5) begin
      btn_n = 1'b0; ticks(3);
      btn_n = 1'b1; ticks(2);
    end
    ticks(10);
    check("glitch_img", 8'(img), 8'd0);
    check("glitch_ready", 8'(req_ready), 8'd1);

    // Short presses cycle the image
    for (int i = 1; i <= 4; i++) begin
      short_press(10);
      check("short_img", 8'(img), 8'(i % 4));
      check("short_led_boot", 8'({led, boot}), 8'd0);
    end

    // Long press from image 2: countdown, setup window, boot
    short_press($urandom_range(8, 15));
    short_press($urandom_range(8, 15));
    check("long_pre_img", 8'(img), 8'd2);
    btn_n = 1'b0;
    nchg = 0; boot_at = -1; prev_led = led;
    for (int c = 0; c < 200; c++) begin
      if (c == 40) btn_n = 1'b1;
      tick();
      if (led !== prev_led && nchg < 8) begin
        chg[nchg] = c; nchg++;
      end
      prev_led = led;
      if (boot === 1'b1 && boot_at < 0) boot_at = c;
    end
    check("long_led_changes", 8'(nchg), 8'd5);
    for (int i = 0; i < 4; i++) check("long_blink_gap", 8'(chg[i+1] - chg[i]), 8'(BLINK));
    check("long_setup_len", 8'(boot_at - chg[4]), 8'(SETUP));
    check("long_sel_boot", 8'({s1, s0, boot, led}), 8'b1011);

    // Abort during the second blink
    pulse_reset();
    k = $urandom_range(0, 3);
    for (int i = 0; i < k; i++) short_press(10);
    btn_n = 1'b0;
    wait_led(1'b1, 60, "abort_arm");
    btn_n = 1'b1;
    wait_led(1'b0, 20, "abort_first_toggle");
    btn_n = 1'b0;
    ticks(12);
    check("abort_led", 8'(led), 8'd0);
    check("abort_img", 8'(img), 8'(k));
    btn_n = 1'b1;
    ticks(10);
    check("abort_idle_ready", 8'(req_ready), 8'd1);
    nb = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (boot !== 1'b0) nb++;
    end
    check("abort_no_boot", 8'(nb), 8'd0);

    // Fabric request
    pulse_reset();
    req_image = 2'd3; req_valid = 1'b1;
    check("req_ready_idle", 8'(req_ready), 8'd1);
    tick();
    req_valid = 1'b0;
    check("req_img_sel", 8'({img, s1, s0, boot}), 8'b11110);
    nb = 0;
    for (int i = 0; i < SETUP - 1; i++) begin
      tick();
      if (boot !== 1'b0) nb++;
    end
    check("req_setup_no_boot", 8'(nb), 8'd0);
    tick();
    check("req_boot", 8'(boot), 8'd1);
    ticks(20);
    check("req_boot_sticky", 8'({boot, s1, s0}), 8'b111);

    // Request while the button is pressed is refused
    pulse_reset();
    btn_n = 1'b0;
    ticks(7);
    req_image = 2'd2; req_valid = 1'b1;
    check("req_blocked_ready", 8'(req_ready), 8'd0);
    tick();
    check("req_blocked_img", 8'({img, boot}), 8'd0);
    ticks(2);
    req_valid = 1'b0;
    btn_n = 1'b1;
    ticks(12);
    check("req_blocked_short", 8'(img), 8'd1);

    // Reset during SETUP and during BOOT
    pulse_reset();
    req_image = 2'($urandom_range(1, 3)); req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    ticks(5);
    pulse_reset();
    check("rst_setup", 8'({boot, img, led, req_ready}), 8'b00001);
    req_image = 2'($urandom_range(1, 3)); req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    ticks(25);
    check("rst_pre_boot", 8'(boot), 8'd1);
    pulse_reset();
    check("rst_boot", 8'({boot, img, led, req_ready}), 8'b00001);

    // Randomized traffic against the model
    for (int it = 0; it < 150; it++) begin
      case ($urandom_range(0, 9))
        0: pulse_reset();
        1, 2: begin
          req_image = 2'($urandom_range(0, 3)); req_valid = 1'b1;
          ticks($urandom_range(1, 3));
          req_valid = 1'b0;
        end
        9: ticks($urandom_range(1, 50));
        default: begin
          btn_n = 1'b0; ticks($urandom_range(1, 40));
          btn_n = 1'b1; ticks($urandom_range(1, 30));
        end
      endcase
    end
    ticks(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
